// File: rtl/unified_mem_arbiter_if.sv
// Bundles the IF fetch port, the MEM load/store port and the shared memory port.
// Carries signals only; request, issue and response timing live in the arbiter.
// Requesters hold req with their attributes until the matching valid pulse.
interface unified_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // instruction fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    logic                  if_stall;

    // load/store port
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [2:0]            dm_funct3;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_valid;
    logic                  dm_stall;

    // shared single-port memory
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_funct3;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // arbiter side
    modport slave (
        input  if_req, if_addr,
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
        input  mem_rdata,
        output if_rdata, if_valid, if_stall,
        output dm_rdata, dm_valid, dm_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
    );

    // core pipeline plus memory array side
    modport master (
        output if_req, if_addr,
        output dm_req, dm_we, dm_addr, dm_wdata, dm_funct3,
        output mem_rdata,
        input  if_rdata, if_valid, if_stall,
        input  dm_rdata, dm_valid, dm_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_funct3
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between fetch (IF) and load/store (MEM); tie policy: MEM_ARB_RR_EN = round-robin, else DM_PRIORITY.
// Latency: issue is combinational, response valid exactly 1 cycle after issue; at most one access per cycle.
// Backpressure: a waiting requester sees *_stall = req & ~valid; the port responding this cycle is masked from issue.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter bit DM_PRIORITY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    unified_mem_arbiter_if.slave bus
);
    // state names the port whose response is due in the current cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  eligible_if;
    logic                  eligible_dm;
    logic                  tie_to_dm;
    logic                  grant_if;
    logic                  grant_dm;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

`ifdef MEM_ARB_RR_EN
    // 1 = the last tie went to DM; reset to DM so the first tie after reset goes to IF
    logic last_grant_dm;

    assign tie_to_dm = ~last_grant_dm;

    // pointer follows tie winners only; uncontested grants leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_dm <= 1'b1;
        end else if (eligible_if && eligible_dm) begin
            last_grant_dm <= grant_dm;
        end
    end
`else
    assign tie_to_dm = DM_PRIORITY;
`endif

    // pick at most one winner; nothing issues while reset is sampled
    always_comb begin
        eligible_if = bus.if_req & (state != RESP_IF);
        eligible_dm = bus.dm_req & (state != RESP_DM);
        grant_dm    = ~reset & eligible_dm & (~eligible_if | tie_to_dm);
        grant_if    = ~reset & eligible_if & ~(eligible_dm & tie_to_dm);
    end

    // response-state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and memory-side issue; fetches are always word reads
    always_comb begin
        state_nxt      = IDLE;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_funct3 = 3'b000;
        sel_addr       = '0;
        sel_wdata      = '0;
        if (grant_dm) begin
            state_nxt      = RESP_DM;
            bus.mem_en     = 1'b1;
            bus.mem_we     = bus.dm_we;
            bus.mem_funct3 = bus.dm_funct3;
            sel_addr       = bus.dm_addr;
            sel_wdata      = bus.dm_wdata;
        end else if (grant_if) begin
            state_nxt      = RESP_IF;
            bus.mem_en     = 1'b1;
            bus.mem_funct3 = 3'b010;
            sel_addr       = bus.if_addr;
        end
        bus.mem_addr  = sel_addr;
        bus.mem_wdata = sel_wdata;
    end

    // route the memory read data to whichever port is due; reset suppresses the pulse
    always_comb begin
        bus.if_valid = 1'b0;
        bus.dm_valid = 1'b0;
        bus.if_rdata = '0;
        bus.dm_rdata = '0;
        if (!reset) begin
            if (state == RESP_IF) begin
                bus.if_valid = 1'b1;
                bus.if_rdata = bus.mem_rdata;
            end
            if (state == RESP_DM) begin
                bus.dm_valid = 1'b1;
                bus.dm_rdata = bus.mem_rdata;
            end
        end
        bus.if_stall = bus.if_req & ~bus.if_valid;
        bus.dm_stall = bus.dm_req & ~bus.dm_valid;
    end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench: reset, lone fetch, store/load, contention and reset mid-access.
// A per-cycle reference model checks every output; literal checks pin the schedule.
// Memory is a behavioural 1-cycle-latency array attached to the shared port.
module tb_unified_mem_arbiter;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam bit DM_PRI = 1'b1;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN  = 1'b1;
`else
    localparam bit RR_EN  = 1'b0;
`endif
    // port that wins a tie straight out of reset
    localparam bit FIRST_DM = RR_EN ? 1'b0 : DM_PRI;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    unified_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DM_PRIORITY(DM_PRI)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [31:0] init_val(input int idx);
        return (idx == 4) ? 32'h0050_0093 : (32'h1000_0000 | idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // memory array on the shared port: writes commit at the issue edge, reads return next cycle
    logic [31:0] mem_arr [0:63];
    bit          mem_wr  [0:63];
    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
                mem_wr[bus.mem_addr[7:2]]  <= 1'b1;
            end else begin
                bus.mem_rdata <= mem_wr[bus.mem_addr[7:2]] ? mem_arr[bus.mem_addr[7:2]]
                                                           : init_val(int'(bus.mem_addr[7:2]));
            end
        end
    end

    // reference model: who is due, tie pointer, expected read data, reference memory
    int          m_due     = 0;      // 0 nobody, 1 IF, 2 DM
    bit          m_last_dm = 1'b1;
    bit          m_store   = 1'b0;
    logic [31:0] m_rdata   = '0;
    logic [31:0] ref_arr [0:63];
    bit          ref_wr  [0:63];

    always @(negedge clk) begin
        int          win;
        int          idx;
        bit          e_if;
        bit          e_dm;
        bit          x_ifv;
        bit          x_dmv;
        logic [31:0] w_addr;
        e_if  = bus.if_req && (m_due != 1);
        e_dm  = bus.dm_req && (m_due != 2);
        x_ifv = !reset && (m_due == 1);
        x_dmv = !reset && (m_due == 2);
        if (reset)              win = 0;
        else if (e_if && e_dm)  win = (RR_EN ? !m_last_dm : DM_PRI) ? 2 : 1;
        else if (e_dm)          win = 2;
        else if (e_if)          win = 1;
        else                    win = 0;
        w_addr = (win == 2) ? bus.dm_addr : bus.if_addr;

        check("mem_en", bus.mem_en, (win != 0));
        check("mem_we", bus.mem_we, (win == 2) && bus.dm_we);
        if (win != 0) begin
            check("mem_addr", bus.mem_addr, w_addr);
            check("mem_funct3", bus.mem_funct3, (win == 1) ? 3'b010 : bus.dm_funct3);
            if (win == 2 && bus.dm_we) check("mem_wdata", bus.mem_wdata, bus.dm_wdata);
        end
        check("if_valid", bus.if_valid, x_ifv);
        check("dm_valid", bus.dm_valid, x_dmv);
        if (x_ifv) check("if_rdata", bus.if_rdata, m_rdata);
        if (x_dmv && !m_store) check("dm_rdata", bus.dm_rdata, m_rdata);
        if (reset) begin
            check("rst_if_rdata", bus.if_rdata, 0);
            check("rst_dm_rdata", bus.dm_rdata, 0);
        end
        check("if_stall", bus.if_stall, bus.if_req && !x_ifv);
        check("dm_stall", bus.dm_stall, bus.dm_req && !x_dmv);

        // advance to the next cycle; inputs are stable until after the coming posedge
        if (reset) begin
            m_due     = 0;
            m_last_dm = 1'b1;
        end else begin
            idx     = int'(w_addr[7:2]);
            m_store = (win == 2) && bus.dm_we;
            if (m_store) begin
                ref_arr[idx] = bus.dm_wdata;
                ref_wr[idx]  = 1'b1;
            end else if (win != 0) begin
                m_rdata = ref_wr[idx] ? ref_arr[idx] : init_val(idx);
            end
            if (e_if && e_dm) m_last_dm = (win == 2);
            m_due = win;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h10;
        bus.dm_req    = 1'b1;
        bus.dm_we     = 1'b0;
        bus.dm_addr   = 32'h40;
        bus.dm_wdata  = '0;
        bus.dm_funct3 = 3'b010;

        // reset held 3 cycles with both requesting: nothing issues or responds
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_mem_en", bus.mem_en, 0);
            check("rst_if_valid", bus.if_valid, 0);
            check("rst_dm_valid", bus.dm_valid, 0);
            step();
        end
        reset = 1'b0;

        // first post-reset cycle issues the tie winner, the other follows
        @(negedge clk);
        check("tie0_mem_en", bus.mem_en, 1);
        check("tie0_addr", bus.mem_addr, FIRST_DM ? 32'h40 : 32'h10);
        step();
        @(negedge clk);
        check("tie1_addr", bus.mem_addr, FIRST_DM ? 32'h10 : 32'h40);
        if (FIRST_DM) check("tie1_dm_valid", bus.dm_valid, 1);
        else          check("tie1_if_rdata", bus.if_rdata, 32'h0050_0093);
        step();
        if (FIRST_DM) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
        @(negedge clk);
        check("tie2_mem_en", bus.mem_en, 0);
        if (FIRST_DM) check("tie2_if_rdata", bus.if_rdata, 32'h0050_0093);
        else          check("tie2_dm_rdata", bus.dm_rdata, 32'h1000_0010);
        step();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
        check("idle_mem_en", bus.mem_en, 0);
        step();

        // lone fetch
        bus.if_req = 1'b1;
        @(negedge clk);
        check("fetch_mem_en", bus.mem_en, 1);
        check("fetch_stall_n", bus.if_stall, 1);
        step();
        @(negedge clk);
        check("fetch_valid", bus.if_valid, 1);
        check("fetch_rdata", bus.if_rdata, 32'h0050_0093);
        check("fetch_stall_n1", bus.if_stall, 0);
        step();
        bus.if_req = 1'b0;
        @(negedge clk);
        check("fetch_done_en", bus.mem_en, 0);
        check("fetch_done_stall", bus.if_stall, 0);
        step();

        // store then load back the same word
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("st_mem_we", bus.mem_we, 1);
        check("st_stall", bus.dm_stall, 1);
        step();
        @(negedge clk);
        check("st_ack", bus.dm_valid, 1);
        check("st_mem_en", bus.mem_en, 0);
        step();
        bus.dm_we = 1'b0;
        @(negedge clk);
        check("ld_mem_en", bus.mem_en, 1);
        step();
        @(negedge clk);
        check("ld_valid", bus.dm_valid, 1);
        check("ld_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        step();
        bus.dm_req = 1'b0;

        // contention from a fresh reset: grants alternate every cycle
        reset = 1'b1;
        step();
        reset      = 1'b0;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("alt_mem_en", bus.mem_en, 1);
            check("alt_addr", bus.mem_addr, (((k % 2) == 0) == FIRST_DM) ? 32'h40 : 32'h10);
            if (k > 0) check("alt_prev_valid", (((k % 2) == 1) == FIRST_DM) ? bus.dm_valid : bus.if_valid, 1);
            step();
        end
        if (FIRST_DM) bus.dm_req = 1'b0; else bus.if_req = 1'b0;
        @(negedge clk);
        check("alt_end_en", bus.mem_en, 0);
        check("alt_end_valid", FIRST_DM ? bus.if_valid : bus.dm_valid, 1);
        step();
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;

        // load issued, then reset in the response cycle: no pulse, back to idle
        bus.dm_req = 1'b1;
        @(negedge clk);
        check("rmid_issue", bus.mem_en, 1);
        step();
        reset = 1'b1;
        @(negedge clk);
        check("rmid_dm_valid", bus.dm_valid, 0);
        check("rmid_mem_en", bus.mem_en, 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("rmid_reissue", bus.mem_en, 1);
        check("rmid_no_valid", bus.dm_valid, 0);
        step();
        @(negedge clk);
        check("rmid_valid", bus.dm_valid, 1);
        check("rmid_rdata", bus.dm_rdata, 32'hDEAD_BEEF);
        step();
        bus.dm_req = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
